// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle core control sequencer:
// state encoding, halt cause codes and RV32I major opcodes.
package core_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_ILLEGAL = 2'd1,
    ERR_TIMEOUT = 2'd2,
    ERR_PC      = 2'd3
  } err_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // True for the opcodes the core executes (SYSTEM excluded: it halts).
  function automatic logic opc_executable(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM: opc_executable = 1'b1;
      default:                               opc_executable = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/core_ctrl_fsm_req_timeout.sv
// Wait counter shared by instruction fetch and data access handshakes.
// 'expired' flags the cycle whose increment brings the count to TIMEOUT,
// so a request gives up after exactly TIMEOUT cycles without ack.
module req_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear outside a handshake, count each unacked request cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, PC update strobes, and sticky halt/error status.
module core_ctrl_fsm
  import core_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        dmem_ack,
  input  logic        branch_taken,
  input  logic        halt_pc,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        pc_imm,
  output logic [31:0] ir,
  output logic        halted,
  output logic [1:0]  err,
  output logic [2:0]  state
);

  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  err_t        err_q, err_d;

  logic       tmo_clr, tmo_inc, tmo_expired;
  logic [6:0] opc;
  logic       is_store, is_branch, is_jump;

  assign opc       = ir_q[6:0];
  assign is_store  = (opc == OPC_STORE);
  assign is_branch = (opc == OPC_BRANCH);
  assign is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);

  req_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmo_clr),
    .inc     (tmo_inc),
    .expired (tmo_expired)
  );

  // Next-state, instruction capture, halt cause and Moore output decode.
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    err_d    = err_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_wen   = 1'b0;
    pc_wen   = 1'b0;
    pc_imm   = 1'b0;
    halted   = 1'b0;
    tmo_clr  = 1'b1;
    tmo_inc  = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        tmo_clr = 1'b0;
        if (halt_pc) begin
          state_d = ST_HALT;
          err_d   = ERR_PC;
        end else begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            state_d = ST_DECODE;
          end else begin
            tmo_inc = 1'b1;
            if (tmo_expired) begin
              state_d = ST_HALT;
              err_d   = ERR_TIMEOUT;
            end
          end
        end
      end
      ST_DECODE: begin
        if (opc == OPC_SYSTEM) begin
          state_d = ST_HALT;
          err_d   = ERR_NONE;
        end else if (opc_executable(opc)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end
      end
      ST_EXEC: begin
        if ((opc == OPC_LOAD) || is_store) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        tmo_clr  = 1'b0;
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (dmem_ack) begin
          state_d = ST_WB;
        end else begin
          tmo_inc = 1'b1;
          if (tmo_expired) begin
            state_d = ST_HALT;
            err_d   = ERR_TIMEOUT;
          end
        end
      end
      ST_WB: begin
        pc_wen  = 1'b1;
        rf_wen  = !(is_store || is_branch);
        pc_imm  = is_jump || (is_branch && branch_taken);
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: begin
        state_d = ST_HALT;
        err_d   = ERR_ILLEGAL;
      end
    endcase
  end

  // State, instruction and error registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

  assign ir    = ir_q;
  assign err   = err_q;
  assign state = state_q;

endmodule

// File: doc/core_ctrl_fsm.md
# core_ctrl_fsm

Multi-cycle control sequencer for the single-issue RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the handshakes to instruction and data memory. It also issues the one-cycle program-counter update pulse and the immediate-select used for branches and jumps. It sits between the program counter, the memories, the register file and the ALU, and owns the core's halt/error status.

## Interface
- `TIMEOUT`, default 255: maximum cycles a memory request may wait for ack before a fault (1..255).
- `clk`  in  1  core clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `imem_ack`  in  1  instruction memory ack; valid only while `imem_req`=1.
- `imem_rdata`  in  32  instruction word; sampled on the edge where `imem_ack`=1.
- `dmem_ack`  in  1  data memory ack; valid only while `dmem_req`=1.
- `branch_taken`  in  1  ALU compare result; sampled in WB.
- `halt_pc`  in  1  program counter out-of-range flag.
- `imem_req`  out  1  instruction fetch request.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data write enable; 1 only for stores while `dmem_req`=1.
- `rf_wen`  out  1  register-file write strobe, one cycle.
- `pc_wen`  out  1  program-counter update strobe, one cycle.
- `pc_imm`  out  1  selects the immediate target for the PC; qualified by `pc_wen`.
- `ir`  out  32  instruction register.
- `halted`  out  1  sticky halt indicator.
- `err`  out  2  halt cause: 0 none/normal, 1 illegal opcode, 2 memory timeout, 3 PC out of range.
- `state`  out  3  current state, for debug.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encoding 7 is unreachable and recovers to HALT with err=1.
- IDLE → FETCH unconditionally.
- FETCH:
  - If `halt_pc`=1: go to HALT with err=3; `imem_req` is not asserted.
  - Otherwise assert `imem_req`. On `imem_ack`=1, load `ir`←`imem_rdata` and go to DECODE.
- DECODE (one cycle) acts on `ir[6:0]`:
  - SYSTEM (1110011): go to HALT, err=0 (ECALL/EBREAK).
  - Any opcode other than LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OP-IMM: go to HALT, err=1.
  - Otherwise go to EXEC.
- EXEC (one cycle): LOAD/STORE go to MEM; all others go to WB.
- MEM: assert `dmem_req`, with `dmem_we`=1 for STORE. On `dmem_ack`=1 go to WB.
- WB (one cycle): assert `pc_wen`=1, then go to FETCH.
  - `rf_wen`=1 for every class except STORE and BRANCH.
  - `pc_imm` = JAL | JALR | (BRANCH & `branch_taken`).
- HALT: all strobes and requests are 0, `halted`=1. Leaves only on `rst`.
- Timeout:
  - A single 8-bit wait counter clears on entering FETCH or MEM and increments each cycle the request is held without ack.
  - When the counter reaches `TIMEOUT` without ack, go to HALT with err=2 and drop the request.
  - An ack arriving on the same cycle as the timeout wins.
- Acks received while the matching request is low are ignored.
- Opcode constants and the state encoding come from the shared package. Nothing is hard-coded locally.

## Timing
- Reset: `rst`=1 at an edge sets state to IDLE, `ir`=0, `err`=0, `halted`=0, counter=0. All outputs are 0 from that edge.
- Reset has priority in every state, including mid-handshake; the request drops on the same edge.
- All outputs are Moore-decoded from registered state, except:
  - `imem_req` is gated by `halt_pc` in FETCH.
  - `pc_imm` uses `branch_taken` in WB.
- Minimum cycles per instruction, with zero-wait memory (ack in the first request cycle):
  - ALU, branch and jump: 4 (FETCH, DECODE, EXEC, WB).
  - Load and store: 5.
- Each wait cycle adds exactly 1.
- `pc_wen` and `rf_wen` are each high for exactly one cycle per retired instruction and are never asserted outside WB.
- The PC value changes after the WB edge, so `halt_pc` is checked in the following FETCH.

## Structure
- Package `core_ctrl_pkg` holds:
  - the state enum (3 bits) and `err` codes;
  - the RV32I opcode constants (OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM, OPC_SYSTEM).
- Sub-module `req_timeout`: 8-bit wait counter with `clr`, `inc` and `expired` (count==`TIMEOUT`). One instance is shared by FETCH and MEM.

## Test plan
- Reset, then OP instruction 0x002081B3 with immediate acks: state sequence 0,1,2,3,5,1. `rf_wen`=1 and `pc_wen`=1 in the same single cycle, `pc_imm`=0. 4 cycles per instruction.
- LW 0x0000A103 with `dmem_ack` delayed 3 cycles: `dmem_req` high for 4 cycles, `dmem_we`=0, `rf_wen` in WB, 8 cycles total. SW 0x0020A023: `dmem_we`=1 and `rf_wen`=0.
- BEQ 0x00208463 with `branch_taken`=1 gives `pc_imm`=1. With `branch_taken`=0 it gives `pc_imm`=0. `rf_wen`=0 in both cases.
- `imem_ack` held low with `TIMEOUT`=8: HALT after 8 request cycles, err=2, `imem_req` drops. A late ack is ignored, and `rst` returns the block to IDLE.
- Illegal opcode 0x0000007F gives HALT with err=1. EBREAK 0x00100073 gives HALT with err=0. `halt_pc`=1 on FETCH entry gives HALT with err=3 and no `imem_req` pulse.
- `rst` asserted mid-MEM with `dmem_req` high: the next edge shows state=0 with all outputs 0.
